// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage bitwise logic unit with valid/ready handshaking
// on both sides and a WIDTH-bit accumulator for the ACC_OR / ACC_XOR ops.
// Stage 1 holds the accepted operands. Stage 2 holds the computed result with
// its zero and parity flags. The result is visible after the second rising edge,
// counting the accepting edge as the first.
module logic_unit_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  typedef enum logic [2:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_XOR     = 3'b010,
    OP_NOR     = 3'b011,
    OP_NAND    = 3'b100,
    OP_XNOR    = 3'b101,
    OP_ACC_OR  = 3'b110,
    OP_ACC_XOR = 3'b111
  } op_e;

  // Stage 1 state
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  op_e              r_s1_op;

  // Stage 2 state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;

  // Handshake and datapath wires
  logic             w_s2_load;
  logic             w_in_xfer;
  logic             w_is_acc;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_alu;

  // S2 accepts a new entry when it is empty or its entry leaves this cycle.
  // in_ready depends on state and out_ready only, so in_valid never loops back.
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_xfer = in_valid && in_ready;

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign parity    = r_parity;

  assign w_is_acc   = (r_s1_op == OP_ACC_OR) || (r_s1_op == OP_ACC_XOR);
  // A clear on the same edge as an ACC load takes effect before the operation.
  assign w_acc_base = acc_clr ? '0 : r_acc;

  // Operation decode for the entry that is sitting in S1
  always_comb begin
    // NOTE: assign a default before the case so that no path leaves w_alu unassigned and infers a latch.
    w_alu = '0;
    unique case (r_s1_op)
      OP_AND:     w_alu = r_s1_a & r_s1_b;
      OP_OR:      w_alu = r_s1_a | r_s1_b;
      OP_XOR:     w_alu = r_s1_a ^ r_s1_b;
      OP_NOR:     w_alu = ~(r_s1_a | r_s1_b);
      OP_NAND:    w_alu = ~(r_s1_a & r_s1_b);
      OP_XNOR:    w_alu = ~(r_s1_a ^ r_s1_b);
      OP_ACC_OR:  w_alu = w_acc_base | r_s1_a;
      OP_ACC_XOR: w_alu = w_acc_base ^ r_s1_a;
      default:    w_alu = '0;
    endcase
  end

  // S1 occupancy: fill on an input transfer, empty when the entry moves to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: use non-blocking assignments for all clocked state so every register samples pre-edge values.
      r_s1_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S1 operand capture
  always_ff @(posedge clk) begin
    // NOTE: the operand registers have no reset because the valid bit qualifies them, which keeps the reset tree small.
    if (w_in_xfer) begin
      r_s1_a  <= a;
      r_s1_b  <= b;
      r_s1_op <= op_e'(op);
    end
  end

  // S2 result register. It holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_parity   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_alu;
      r_zero     <= (w_alu == '0);
      r_parity   <= ^w_alu;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Accumulator: an ACC op entering S2 writes its result here.
  // Otherwise a clear request zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_s2_load && w_is_acc) begin
      r_acc <= w_alu;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe (WIDTH=4). A queue holds the expected results
// in acceptance order. A negedge monitor pops one entry per output transfer
// and compares it with the DUT outputs.
module tb_logic_unit_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         parity;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare every output transfer with the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got result %b, expected no output", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_result", 64'(result), 64'(mon_e));
        check("sb_zero",   64'(zero),   64'(mon_e == '0));
        check("sb_parity", 64'(parity), 64'(^mon_e));
      end
    end
  end

  // Present one operand set. Hold it until it is accepted and record the expected result.
  // The task is called at posedge+1 and returns at posedge+1.
  task automatic send(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] e);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    op       = o;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, expected 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
      // Garbage on the operand bus while idle must be ignored
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom);
    end
  endtask

  // Wait (bounded) until every expected result has been delivered
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, a, b, expected result
    vecs[0]  = '{3'b000, 4'b1100, 4'b1010, 4'b1000};
    vecs[1]  = '{3'b001, 4'b1100, 4'b1010, 4'b1110};
    vecs[2]  = '{3'b010, 4'b1100, 4'b1010, 4'b0110};
    vecs[3]  = '{3'b011, 4'b1100, 4'b1010, 4'b0001};
    vecs[4]  = '{3'b100, 4'b1100, 4'b1010, 4'b0111};
    vecs[5]  = '{3'b101, 4'b1100, 4'b1010, 4'b1001};
    vecs[6]  = '{3'b000, 4'b0000, 4'b1111, 4'b0000};
    vecs[7]  = '{3'b101, 4'b1111, 4'b1111, 4'b1111};
    vecs[8]  = '{3'b100, 4'b1111, 4'b1111, 4'b0000};
    vecs[9]  = '{3'b110, 4'b0011, 4'b1111, 4'b0011};  // acc 0 | 0011, b ignored
    vecs[10] = '{3'b111, 4'b0001, 4'b0110, 4'b0010};  // acc 0011 ^ 0001

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // Reset state, checked while reset is asserted
    #12;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result",    64'(result),    64'(0));
    check("rst_zero",      64'(zero),      64'(1));
    check("rst_parity",    64'(parity),    64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Table of vectors sent back to back
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    drain();

    // OR pair on consecutive cycles, with a latency check
    check("or_idle", 64'(out_valid), 64'(0));
    send(3'b001, 4'b1110, 4'b0100, 4'b1110);
    check("or_lat_early", 64'(out_valid), 64'(0));
    send(3'b001, 4'b1111, 4'b1010, 4'b1111);
    check("or_lat_valid",  64'(out_valid), 64'(1));
    check("or_lat_result", 64'(result),    64'(4'b1110));
    drain();

    // NOR down to zero
    send(3'b011, 4'b1111, 4'b0000, 4'b0000);
    drain();

    // Backpressure: two held entries, then release
    out_ready = 1'b0;
    send(3'b010, 4'b1100, 4'b1010, 4'b0110);
    send(3'b000, 4'b1100, 4'b1010, 4'b1000);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid",  64'(out_valid), 64'(1));
      check("bp_hold_result", 64'(result),    64'(4'b0110));
      check("bp_hold_zero",   64'(zero),      64'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Accumulate sequence after a clear pulse
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    send(3'b110, 4'b0001, 4'b1011, 4'b0001);
    send(3'b110, 4'b0100, 4'b0000, 4'b0101);
    send(3'b111, 4'b0101, 4'b1111, 4'b0000);
    drain();

    // Clear collision: build acc=0101, then a clear on the edge ACC_OR 0010 loads into S2
    send(3'b110, 4'b0101, 4'b0000, 4'b0101);
    send(3'b110, 4'b0010, 4'b0000, 4'b0010);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    // acc must now be 0010: OR with zero exposes it
    send(3'b110, 4'b0000, 4'b1111, 4'b0010);
    drain();

    // Reset mid-stream with two entries in flight
    out_ready = 1'b0;
    send(3'b001, 4'b1010, 4'b0101, 4'b1111);
    send(3'b110, 4'b0110, 4'b0000, 4'b0110);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready",  64'(in_ready),  64'(1));
    check("mid_rst_result",    64'(result),    64'(0));
    check("mid_rst_zero",      64'(zero),      64'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    send(3'b110, 4'b1000, 4'b0111, 4'b1000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
